// File: rtl/vga_line_fetch.sv
// Wishbone line prefetcher: fills the hidden bank of a double-buffered line, then swaps banks on completion.
// Zero-wait line takes WORDS bus cycles plus one swap cycle; a stalled ack simply holds the bus request.
module vga_line_fetch #(
  parameter logic [31:0] VGA_MEMBASE = 32'hc0000000,
  parameter int          WORDS       = 40,
  parameter int          IDXW        = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            line_start,
  input  logic [31:0]     line_addr,
  output logic            busy,
  output logic            done,
  output logic            overrun,
  input  logic            overrun_clr,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [3:0]      sel_o,
  output logic [31:0]     adr_o,
  input  logic [31:0]     dat_i,
  input  logic            ack_i,
  input  logic [IDXW-1:0] rd_idx,
  output logic [31:0]     rd_data,
  output logic            disp_bank
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_cnt;
  logic [31:0]     r_adr;
  logic            r_cyc;
  logic            r_busy;
  logic            r_done;
  logic            r_ovr;
  logic            r_disp;
  logic [31:0]     r_rd;
  logic [31:0]     r_mem [2][WORDS];
  logic            w_fill;
  logic            w_wr;

  assign w_fill = ~r_disp;
  assign w_wr   = !rst_i && (r_state == S_BUS) && ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_cyc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_disp  <= 1'b0;
    end else begin
      // A fresh overrun outranks a clear arriving in the same cycle.
      if (line_start && (r_state != S_IDLE))
        r_ovr <= 1'b1;
      else if (overrun_clr)
        r_ovr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (line_start) begin
            r_adr   <= VGA_MEMBASE + line_addr;
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (ack_i) begin
            if (r_cnt == LAST_IDX) begin
              r_cyc   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_adr <= r_adr + 32'd4;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_disp  <= ~r_disp;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk_i) begin
    if (w_wr)
      r_mem[w_fill][r_cnt] <= dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rd <= '0;
    else if (rd_idx > LAST_IDX)
      r_rd <= '0;
    else
      r_rd <= r_mem[r_disp][rd_idx];
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_ovr;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign we_o      = 1'b0;
  assign sel_o     = 4'hf;
  assign adr_o     = r_adr;
  assign rd_data   = r_rd;
  assign disp_bank = r_disp;

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Single-clock Wishbone line prefetcher for the VGA text path. On each line-start request it reads a fixed number of 32-bit words of video memory into the fill bank of a double-buffered line buffer, then swaps banks so the text renderer reads a complete, stable line from the display bank. It sits between the system Wishbone bus, which it masters, and the text driver, which it feeds through a synchronous read port. It removes per-pixel bus latency from the display path.

## Interface

Parameters:
- VGA_MEMBASE, 32'hc0000000, base byte address of video memory.
- WORDS, 40, 32-bit words fetched per line (2 ≤ WORDS ≤ 2^IDXW).
- IDXW, 6, width of the word index and read index.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- line_start  in  1  one-cycle request to fetch a line.
- line_addr  in  32  byte offset of the line, added to VGA_MEMBASE; sampled when line_start is accepted.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when a line completes and banks swap.
- overrun  out  1  sticky: line_start arrived while busy.
- overrun_clr  in  1  clears overrun.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  constant 0.
- sel_o  out  4  constant 4'hf.
- adr_o  out  32  Wishbone byte address.
- dat_i  in  32  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- rd_idx  in  IDXW  display-bank word index.
- rd_data  out  32  display-bank word, registered.
- disp_bank  out  1  current display bank, for debug.

## Operation

- Storage is two banks of WORDS×32 bits: fill bank = ~disp_bank.
- The state machine has three states: IDLE, BUS, DONE.
- **IDLE**
  - When line_start=1: latch addr = VGA_MEMBASE + line_addr (32-bit, wraps modulo 2^32), set cnt=0, go to BUS.
  - busy=0.
- **BUS**
  - cyc_o=stb_o=1 and adr_o = addr + {cnt,2'b00} (32-bit wrap). busy=1.
  - On ack_i: write dat_i to fill[cnt].
  - If cnt==WORDS-1, go to DONE. Otherwise increment cnt and stay in BUS with stb held high; the new address appears the next cycle.
  - Without ack_i: hold all outputs and stay in BUS. There is no timeout.
- **DONE**
  - cyc_o=stb_o=0, done=1, disp_bank toggles at the clock edge, busy=1.
  - Next state is IDLE.
- **line_start while busy (BUS or DONE)**
  - The request is ignored and overrun is set to 1.
  - If overrun_clr and a new overrun occur in the same cycle, set wins.
- **Read port**
  - rd_data <= disp[rd_idx] each cycle. If rd_idx ≥ WORDS, rd_data <= 0.
  - A read in the swap cycle uses the pre-swap bank. Reads in the following cycle use the new bank.
- The display bank is never written. The fill bank is never readable.
- **Reset mid-fetch**
  - cyc_o/stb_o drop in the next cycle and the partial line is discarded.
  - Buffer contents are not cleared.

## Timing

- Reset values:
  - cyc_o=0, stb_o=0, adr_o=0, busy=0, done=0, overrun=0, disp_bank=0, rd_data=0.
  - we_o=0 and sel_o=4'hf at all times.
- line_start accepted at edge k gives cyc_o=stb_o=1 with the first address in cycle k+1.
- With zero-wait ack (ack_i high in the first cycle of each address), the line takes WORDS cycles in BUS, then one DONE cycle. done is asserted WORDS+1 cycles after acceptance.
- The earliest next line_start is accepted in the cycle after DONE, in IDLE.
- All outputs are registered or decoded from state only, with no combinational path from inputs. The exception is adr_o, which comes from registered cnt.
- rd_data latency is 1 cycle from rd_idx.

## Test plan

- **Zero-wait fetch:** reset, line_addr=0x100, memory model returns dat=adr^0xA5A5A5A5 with ack every cycle.
  - Addresses run 0xc0000100..0xc000019c.
  - done fires at +41 cycles and disp_bank becomes 1.
  - rd_idx=0..39 returns the matching words one cycle later.
- **Wait states:** the model inserts 3 idle cycles before every ack.
  - adr/stb hold steady while waiting.
  - done at +161 cycles with data identical to the zero-wait case.
- **Overrun:** pulse line_start at cycle 10 of a fetch.
  - The fetch continues unchanged and overrun=1.
  - overrun_clr returns it to 0.
  - Asserting clr together with a new overrun leaves overrun=1.
- **Double buffering:** fetch line A, then line B, reading rd_idx=5 continuously.
  - Returns A's word until the B swap cycle, then B's word the cycle after.
  - The display bank never shows a partial line.
- **Wrap and range:** VGA_MEMBASE=0xfffffff0, line_addr=0.
  - Addresses wrap to 0x00000000 after 0xfffffffc.
  - rd_idx=63 returns 0.
- **Reset mid-fetch:** assert rst_i at word 7.
  - cyc_o=0 the next cycle, disp_bank=0, busy=0.
  - A new fetch after reset completes correctly.
